// File: rtl/jogo_sequencia_unidade_controle.sv
// Control unit for the sequence-memory game: growing rounds up to a level-selected limit,
// with per-play timeout. Owns address, round and timer counters; all outputs registered.
module jogo_sequencia_unidade_controle #(
  parameter int unsigned SEQ_LEN     = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned TMR_W       = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  input  logic              nivel,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    PROXIMA_RODADA = 4'h3,
    ESPERA_JOGADA  = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PROXIMO        = 4'h7,
    FIM_ACERTOS    = 4'hC,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(SEQ_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_HALF = ADDR_W'(SEQ_LEN / 2 - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  state_t            state;
  state_t            state_n;
  logic [TMR_W-1:0]  timer;
  logic              nivel_reg;
  logic [ADDR_W-1:0] last_round;

  // Final round index for the level latched at game start.
  assign last_round = nivel_reg ? LAST_FULL : LAST_HALF;

  // Next-state logic; play beats timer expiry when both happen together.
  always_comb begin
    state_n = state;
    case (state)
      INICIAL:        if (iniciar) state_n = PREPARACAO;
      PREPARACAO:     state_n = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada)                 state_n = REGISTRA;
        else if (timer == TMR_LAST) state_n = FIM_TIMEOUT;
      end
      REGISTRA:       state_n = COMPARA;
      COMPARA: begin
        if (!igual)                     state_n = FIM_ERRO;
        else if (endereco != rodada)    state_n = PROXIMO;
        else if (rodada == last_round)  state_n = FIM_ACERTOS;
        else                            state_n = PROXIMA_RODADA;
      end
      PROXIMO:        state_n = ESPERA_JOGADA;
      PROXIMA_RODADA: state_n = ESPERA_JOGADA;
      FIM_ACERTOS,
      FIM_TIMEOUT,
      FIM_ERRO:       if (iniciar) state_n = PREPARACAO;
      default:        state_n = INICIAL;
    endcase
  end

  // State, counters, and Moore outputs decoded from the next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= INICIAL;
      endereco  <= '0;
      rodada    <= '0;
      timer     <= '0;
      nivel_reg <= 1'b0;
      zeraR     <= 1'b1;
      registraR <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= 4'h0;
    end else begin
      state <= state_n;
      case (state)
        PREPARACAO: begin
          endereco  <= '0;
          rodada    <= '0;
          timer     <= '0;
          nivel_reg <= nivel;
        end
        ESPERA_JOGADA: timer <= timer + TMR_W'(1);
        PROXIMO: begin
          endereco <= endereco + ADDR_W'(1);
          timer    <= '0;
        end
        PROXIMA_RODADA: begin
          rodada   <= rodada + ADDR_W'(1);
          endereco <= '0;
          timer    <= '0;
        end
        default: ;
      endcase
      zeraR     <= (state_n == INICIAL) || (state_n == PREPARACAO);
      registraR <= (state_n == REGISTRA);
      acertou   <= (state_n == FIM_ACERTOS);
      errou     <= (state_n == FIM_ERRO);
      timeout   <= (state_n == FIM_TIMEOUT);
      pronto    <= (state_n == FIM_ACERTOS) || (state_n == FIM_ERRO) ||
                   (state_n == FIM_TIMEOUT);
      db_estado <= state_n;
    end
  end

endmodule

// File: tb/tb_jogo_sequencia_unidade_controle.sv
// Scoreboard bench for the game control unit: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_jogo_sequencia_unidade_controle;

  localparam int unsigned SEQ_LEN     = 4;
  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned TIMEOUT_CYC = 10;
  localparam int unsigned TMR_W       = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic              jogada;
  logic              igual;
  logic              nivel;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] rodada;
  logic              zeraR;
  logic              registraR;
  logic              acertou;
  logic              errou;
  logic              timeout;
  logic              pronto;
  logic [3:0]        db_estado;

  jogo_sequencia_unidade_controle #(
    .SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC), .TMR_W(TMR_W)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .nivel(nivel), .endereco(endereco), .rodada(rodada), .zeraR(zeraR),
    .registraR(registraR), .acertou(acertou), .errou(errou), .timeout(timeout),
    .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [13:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [13:0] mon_exp;
  string       mon_name;
  logic [13:0] act;

  assign act = {db_estado, endereco, rodada, zeraR, registraR, acertou, errou, timeout, pronto};

  function automatic logic [13:0] mk(input logic [3:0] st, input logic [1:0] e, input logic [1:0] r);
    logic zr, rr, ac, er, to, pr;
    zr = (st == 4'h0) || (st == 4'h1);
    rr = (st == 4'h5);
    ac = (st == 4'hC);
    er = (st == 4'hE);
    to = (st == 4'hD);
    pr = ac | er | to;
    return {st, e, r, zr, rr, ac, er, to, pr};
  endfunction

  task automatic expect_st(input string nm, input logic [3:0] st, input int e, input int r);
    exp_q.push_back(mk(st, 2'(e), 2'(r)));
    name_q.push_back(nm);
  endtask

  // Monitor: one queued snapshot compared per falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checks++;
      if (act !== mon_exp) begin
        failures++;
        $display("FAIL %s: got st=%h end=%0d rod=%0d zr,rr,ac,er,to,pr=%b expected st=%h end=%0d rod=%0d zr,rr,ac,er,to,pr=%b",
                 mon_name, act[13:10], act[9:8], act[7:6], act[5:0],
                 mon_exp[13:10], mon_exp[9:8], mon_exp[7:6], mon_exp[5:0]);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Start from inicial or an end state; old_e/old_r are still visible during preparacao.
  task automatic start(input string nm, input bit nv, input int old_e, input int old_r);
    nivel   = nv;
    iniciar = 1'b1;
    tick;
    expect_st({nm, " prep"}, 4'h1, old_e, old_r);
    iniciar = 1'b0;
    tick;
    expect_st({nm, " wait"}, 4'h4, 0, 0);
  endtask

  // One play from espera_jogada, following it through to the next wait or end state.
  task automatic play(input string nm, input bit ok, inout int e, inout int r, input int lim);
    jogada = 1'b1;
    igual  = ok;
    tick;
    jogada = 1'b0;
    expect_st($sformatf("%s r%0d e%0d reg", nm, r, e), 4'h5, e, r);
    tick;
    expect_st($sformatf("%s r%0d e%0d cmp", nm, r, e), 4'h6, e, r);
    tick;
    if (!ok) begin
      expect_st($sformatf("%s r%0d e%0d erro", nm, r, e), 4'hE, e, r);
    end else if (e != r) begin
      expect_st($sformatf("%s r%0d e%0d prox", nm, r, e), 4'h7, e, r);
      tick;
      e++;
      expect_st($sformatf("%s r%0d e%0d wait", nm, r, e), 4'h4, e, r);
    end else if (r == lim - 1) begin
      expect_st($sformatf("%s r%0d e%0d win", nm, r, e), 4'hC, e, r);
    end else begin
      expect_st($sformatf("%s r%0d e%0d nxtrod", nm, r, e), 4'h3, e, r);
      tick;
      r++;
      e = 0;
      expect_st($sformatf("%s r%0d e%0d wait", nm, r, e), 4'h4, e, r);
    end
  endtask

  task automatic run_game(input string nm, input int lim, inout int e, inout int r);
    e = 0;
    r = 0;
    for (int rd = 0; rd < lim; rd++)
      for (int k = 0; k <= rd; k++)
        play(nm, 1'b1, e, r, lim);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r;
    reset   = 1'b0;
    iniciar = 1'b0;
    jogada  = 1'b0;
    igual   = 1'b0;
    nivel   = 1'b0;

    // Reset state and release.
    tick;
    tick;
    expect_st("in reset", 4'h0, 0, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick;
    expect_st("after reset", 4'h0, 0, 0);

    // Full game at nivel=1: 10 plays, ends in fim_acertos and holds.
    start("g1", 1'b1, 0, 0);
    run_game("g1", 4, e, r);
    tick;
    expect_st("g1 hold", 4'hC, 3, 3);

    // Half game at nivel=0; nivel toggled mid-game must not matter.
    start("g2", 1'b0, 3, 3);
    nivel = 1'b1;
    run_game("g2", 2, e, r);

    // Wrong play on round 2, second play; iniciar in espera_jogada ignored.
    start("g3", 1'b1, 1, 1);
    iniciar = 1'b1;
    tick;
    expect_st("g3 ignore iniciar", 4'h4, 0, 0);
    iniciar = 1'b0;
    e = 0;
    r = 0;
    play("g3", 1'b1, e, r, 4);
    play("g3", 1'b1, e, r, 4);
    play("g3", 1'b0, e, r, 4);
    tick;
    expect_st("g3 erro hold", 4'hE, 1, 1);

    // Timeout after 10 idle cycles.
    start("g4", 1'b1, 1, 1);
    for (int i = 0; i < 9; i++) begin
      tick;
      expect_st($sformatf("g4 idle %0d", i + 2), 4'h4, 0, 0);
    end
    tick;
    expect_st("g4 timeout", 4'hD, 0, 0);

    // Play on exactly the 10th cycle wins over expiry.
    start("g5", 1'b1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick;
      expect_st($sformatf("g5 idle %0d", i + 2), 4'h4, 0, 0);
    end
    e = 0;
    r = 0;
    play("g5", 1'b1, e, r, 4);
    play("g5", 1'b1, e, r, 4);
    jogada = 1'b1;
    igual  = 1'b1;
    tick;
    jogada = 1'b0;
    expect_st("g5 reg before abort", 4'h5, 1, 1);
    tick;
    expect_st("g5 cmp before abort", 4'h6, 1, 1);

    // Async reset while in compara.
    #5;
    reset = 1'b0;
    #1;
    expect_st("abort in reset", 4'h0, 0, 0);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    tick;
    expect_st("after abort", 4'h0, 0, 0);
    start("g6", 1'b0, 0, 0);

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected snapshots left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
